unidad_mac_stream: RTL and testbench
====================================

Name: unidad_mac_stream

Overview:
- Parametrised streaming multiply-accumulate unit; successor to the single-cycle add/sub arithmetic unit.
- Accepts a packet of (A,B) operand beats with first/last framing and a per-beat add/subtract op, and seeds the accumulator with an input C term on the first beat.
- Emits one WIDTH-bit signed result per packet, with an overflow flag, over a valid/ready handshake.
- Sits between the matrix-row/column sequencer and the result register bank of the 4x4 matrix multiplier; one instance computes one dot product.

Parameters:
- WIDTH, 8, signed operand and result width.
- GUARD, 4, extra accumulator guard bits; the internal accumulator is ACC_W = 2*WIDTH+GUARD bits wide.

Ports:
- CLK  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  WIDTH  signed multiplicand.
- in_b  in  WIDTH  signed multiplier.
- in_c  in  WIDTH  signed seed, sampled only on first beats.
- in_op  in  1  0: acc += a*b; 1: acc -= a*b.
- in_first  in  1  beat starts a packet.
- in_last  in  1  beat ends a packet.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  signed result.
- out_ovf  out  1  the packet overflowed.
- clr_err  in  1  synchronous clear of err.
- err  out  1  sticky: set by any packet overflow.

Behaviour:
- Reset (reset=0, asynchronous): all pipeline registers, the accumulator, out_valid, out_data, out_ovf and err go to 0. in_ready reads 1 after reset releases.
  - Reset mid-packet discards the partial packet.
- Handshake: a beat transfers when in_valid && in_ready. A result transfers when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready. in_ready = !stall. During a stall every pipeline stage holds its contents; no data is lost.
- Stage 1, product: on each accepted beat, register p = a*b as a full 2*WIDTH signed product, together with op, first, last and c.
- Stage 2, accumulate: base = first ? sext(c) : acc_prev. acc = op ? base - sext(p) : base + sext(p), computed at ACC_W bits.
  - A beat with first=0 arriving after a last beat uses base = 0.
  - A beat that has both first=1 and last=1 is a single-term packet.
- Overflow tracking:
  - Packet overflow flag pkt_ovf is set if any ACC_W add/sub overflows (operand signs equal, result sign different).
  - pkt_ovf is also set if, on the last beat, acc lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - pkt_ovf clears on the first beat of the next packet.
- Output: on the last beat, register out_data (see Optional Feature), out_ovf = pkt_ovf, and out_valid=1. out_valid clears on the transfer edge unless a new last beat completes in the same cycle.
- Latency: a last beat accepted at edge t gives out_valid=1 after edge t+2. Throughput is one beat per cycle when not stalled.
- err:
  - Set on the edge where a result with out_ovf=1 is registered.
  - clr_err=1 clears it. If a set and clr_err occur in the same cycle, the set wins.
  - err is not cleared by packet boundaries.
- Non-first beat with no open packet (after reset): treated as base = 0, with no error.
- in_c is ignored on beats with first=0.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: an out-of-range result clamps to 2^(WIDTH-1)-1 (positive) or -2^(WIDTH-1) (negative). If the ACC_W accumulator itself overflowed, the clamp uses the sign of the true result, tracked via the carry.
- Undefined: out_data = acc[WIDTH-1:0] (two's-complement wrap).
- out_ovf and err behave identically in both builds.

Decomposition:
- Package mac_pkg: the ACC_W computation, the op encoding constants OP_ADD=0 and OP_SUB=1, and the signed max/min constant functions for a given width.
- Sub-module mac_sat_trunc (combinational): takes the ACC_W accumulator plus the overflow flag and produces the WIDTH-bit result and the range-overflow bit. It contains the MAC_SAT_EN conditional.

Test Plan (WIDTH=8, GUARD=4):
- Single-term packet: a=3, b=4, c=5, op=0, first=last=1 -> out_data=17, out_ovf=0, out_valid 2 cycles after acceptance.
- Four-beat dot product: (1,2),(3,4),(5,6),(7,8), c=0, all adds, back-to-back -> out_data=100; next packet's beats accepted with no bubble.
- Subtract: c=10, a=4, b=5, op=1 -> out_data=-10 (0xF6), out_ovf=0.
- Overflow: a=127, b=127, c=0 -> out_ovf=1, err=1.
  - MAC_SAT_EN defined: out_data=127.
  - MAC_SAT_EN undefined: out_data=0x01.
  - err stays 1 over later clean packets until clr_err is pulsed.
- Backpressure: two single-term packets sent with out_ready=0 -> in_ready drops after the first result; out_data holds the first result; release out_ready -> both results delivered in order, none lost.
- Reset mid-packet: two beats accepted, then reset pulsed low mid-cycle -> all outputs 0 immediately; packet (2,3) with c=1 afterwards -> 7.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared definitions for the streaming MAC: accumulator sizing, op encoding
// and signed range limits.
package mac_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int acc_width(input int width, input int guard);
        return 2 * width + guard;
    endfunction

    function automatic int signed_max(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    function automatic int signed_min(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/mac_sat_trunc.sv
// Reduces the wide accumulator to a WIDTH-bit result and flags out-of-range values.
// MAC_SAT_EN defined: out-of-range results clamp; otherwise they wrap.
module mac_sat_trunc
    import mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 20
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic                    acc_ovf,
    input  logic                    true_neg,
    output logic [WIDTH-1:0]        result,
    output logic                    range_ovf
);

    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(signed_max(WIDTH));
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(signed_min(WIDTH));

    logic neg;
    logic hi;
    logic lo;

    // Once the wide accumulator has wrapped its MSB lies, so the direction
    // comes from the carry-derived sign instead.
    always_comb begin
        neg       = acc_ovf ? true_neg : acc[ACC_W-1];
        hi        = !neg && (acc_ovf || (acc > MAX_V));
        lo        = neg && (acc_ovf || (acc < MIN_V));
        range_ovf = hi || lo;
`ifdef MAC_SAT_EN
        if (hi)
            result = WIDTH'(signed_max(WIDTH));
        else if (lo)
            result = WIDTH'(signed_min(WIDTH));
        else
            result = acc[WIDTH-1:0];
`else
        result = acc[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/unidad_mac_stream.sv
// Streaming signed multiply-accumulate: product stage, accumulate stage, output register.
// MAC_SAT_EN selects saturating (defined) or wrapping (undefined) result reduction.
module unidad_mac_stream
    import mac_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GUARD = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic             in_op,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_err,
    output logic             err
);

    localparam int ACC_W  = acc_width(WIDTH, GUARD);
    localparam int PROD_W = 2 * WIDTH;
    localparam int WIDE_W = ACC_W + 1;

    logic stall;

    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_p;
    logic signed [WIDTH-1:0]  s1_c;
    logic                     s1_op;
    logic                     s1_first;
    logic                     s1_last;
    logic signed [PROD_W-1:0] prod_next;

    logic                     s2_valid;
    logic                     s2_last;
    logic signed [ACC_W-1:0]  acc;
    logic                     pkt_ovf;
    logic                     true_neg;

    logic signed [ACC_W-1:0]  base;
    logic signed [ACC_W-1:0]  p_ext;
    logic signed [WIDE_W-1:0] wide;
    logic                     ovf_prev;
    logic                     add_ovf;

    logic [WIDTH-1:0]         res_data;
    logic                     range_ovf;
    logic                     res_done;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign prod_next = PROD_W'($signed(in_a)) * PROD_W'($signed(in_b));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_c     <= '0;
            s1_op    <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_p     <= prod_next;
                s1_c     <= $signed(in_c);
                s1_op    <= in_op;
                s1_first <= in_first;
                s1_last  <= in_last;
            end
        end
    end

    // A beat that follows a completed packet without first set starts from zero.
    always_comb begin
        base     = acc;
        ovf_prev = pkt_ovf;
        if (s1_first) begin
            base     = ACC_W'(s1_c);
            ovf_prev = 1'b0;
        end else if (s2_last) begin
            base     = '0;
            ovf_prev = 1'b0;
        end
        p_ext = ACC_W'(s1_p);
        if (s1_op == OP_ADD)
            wide = WIDE_W'(base) + WIDE_W'(p_ext);
        else
            wide = WIDE_W'(base) - WIDE_W'(p_ext);
        add_ovf = wide[ACC_W] != wide[ACC_W-1];
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            acc      <= '0;
            pkt_ovf  <= 1'b0;
            true_neg <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                acc      <= wide[ACC_W-1:0];
                pkt_ovf  <= ovf_prev || add_ovf;
                true_neg <= wide[ACC_W];
                s2_last  <= s1_last;
            end
        end
    end

    mac_sat_trunc #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_sat_trunc (
        .acc       (acc),
        .acc_ovf   (pkt_ovf),
        .true_neg  (true_neg),
        .result    (res_data),
        .range_ovf (range_ovf)
    );

    assign res_done = !stall && s2_valid && s2_last;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid && s2_last;
            if (res_done) begin
                out_data <= res_data;
                out_ovf  <= range_ovf;
            end
        end
    end

    // A new overflowing result takes priority over a clear in the same cycle.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (res_done && range_ovf)
            err <= 1'b1;
        else if (clr_err)
            err <= 1'b0;
    end

endmodule

// File: tb/tb_unidad_mac_stream.sv
// Directed self-checking bench for unidad_mac_stream (WIDTH=8, GUARD=4).
// Expected values adapt to the MAC_SAT_EN build.
module tb_unidad_mac_stream;

    logic       CLK = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [7:0] in_c;
    logic       in_op;
    logic       in_first;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic       clr_err;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0] d;
        logic       o;
        int         cyc;
    } res_t;
    res_t q[$];

    unidad_mac_stream #(.WIDTH(8), .GUARD(4)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_op     (in_op),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .clr_err   (clr_err),
        .err       (err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Inputs only move at negedge (+1) and posedge (+1), so +2 after negedge is stable.
    always @(negedge CLK) begin
        #2;
        if (reset && out_valid && out_ready)
            q.push_back('{d: out_data, o: out_ovf, cyc: cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic op, input logic first, input logic last,
                        output int acyc);
        int waits = 0;
        @(negedge CLK);
        in_a = a; in_b = b; in_c = c; in_op = op; in_first = first; in_last = last;
        in_valid = 1'b1;
        #1;
        while (!in_ready && waits < 100) begin
            @(negedge CLK);
            #1;
            waits++;
        end
        if (waits >= 100)
            check("accept_timeout", in_ready, 1);
        @(posedge CLK);
        #1;
        acyc     = cyc;
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [7:0] d, input logic o,
                                 output int rcyc);
        int   n = 0;
        res_t r;
        while (q.size() == 0 && n < 200) begin
            @(negedge CLK);
            #3;
            n++;
        end
        check({tag, "_present"}, q.size() != 0, 1);
        rcyc = -1;
        if (q.size() != 0) begin
            r = q.pop_front();
            check({tag, "_data"}, r.d, d);
            check({tag, "_ovf"}, r.o, o);
            rcyc = r.cyc;
        end
    endtask

    task automatic pulse_clr();
        @(negedge CLK);
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        #1;
    endtask

    initial begin
        int ac, ac1, ac2, rc;
        logic [7:0] exp_big, exp_neg, exp_128, exp_m129, exp_wrap;

`ifdef MAC_SAT_EN
        exp_big  = 8'h7F;
        exp_neg  = 8'h80;
        exp_128  = 8'h7F;
        exp_m129 = 8'h80;
        exp_wrap = 8'h7F;
`else
        exp_big  = 8'h01;
        exp_neg  = 8'h64;
        exp_128  = 8'h80;
        exp_m129 = 8'h7F;
        exp_wrap = 8'h00;
`endif

        reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0;
        in_op = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_ovf", out_ovf, 0);
        check("rst_err", err, 0);
        check("rst_in_ready", in_ready, 1);

        // Single-term packet and its latency.
        send(8'd3, 8'd4, 8'd5, 1'b0, 1'b1, 1'b1, ac);
        expect_result("single", 8'd17, 1'b0, rc);
        check("latency", rc - ac, 2);

        // Two back-to-back four-beat packets.
        send(8'd1, 8'd2, 8'd0, 1'b0, 1'b1, 1'b0, ac);
        send(8'd3, 8'd4, 8'd0, 1'b0, 1'b0, 1'b0, ac);
        send(8'd5, 8'd6, 8'd0, 1'b0, 1'b0, 1'b0, ac);
        send(8'd7, 8'd8, 8'd0, 1'b0, 1'b0, 1'b1, ac1);
        send(8'd2, 8'd2, 8'hFD, 1'b0, 1'b1, 1'b0, ac2);
        check("no_bubble", ac2 - ac1, 1);
        send(8'd2, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, ac);
        send(8'd2, 8'd2, 8'd0, 1'b0, 1'b0, 1'b0, ac);
        send(8'd2, 8'd2, 8'd0, 1'b0, 1'b0, 1'b1, ac);
        expect_result("dot4", 8'd100, 1'b0, rc);
        expect_result("dot4b", 8'd13, 1'b0, rc);

        send(8'd4, 8'd5, 8'd10, 1'b1, 1'b1, 1'b1, ac);
        expect_result("sub", 8'hF6, 1'b0, rc);

        // Range boundaries.
        send(8'd0, 8'd0, 8'h7F, 1'b0, 1'b1, 1'b1, ac);
        expect_result("max", 8'h7F, 1'b0, rc);
        send(8'd0, 8'd0, 8'h80, 1'b0, 1'b1, 1'b1, ac);
        expect_result("min", 8'h80, 1'b0, rc);
        check("err_clean", err, 0);
        send(8'd1, 8'd1, 8'h7F, 1'b0, 1'b1, 1'b1, ac);
        expect_result("p128", exp_128, 1'b1, rc);
        check("err_p128", err, 1);
        pulse_clr();
        check("err_cleared1", err, 0);
        send(8'd1, 8'd1, 8'h80, 1'b1, 1'b1, 1'b1, ac);
        expect_result("m129", exp_m129, 1'b1, rc);
        pulse_clr();

        // Overflow registered while clr_err is held: the set wins.
        @(negedge CLK);
        clr_err = 1'b1;
        send(8'd127, 8'd127, 8'd0, 1'b0, 1'b1, 1'b1, ac);
        expect_result("big", exp_big, 1'b1, rc);
        clr_err = 1'b0;
        #1;
        check("err_set_wins", err, 1);
        send(8'd3, 8'd4, 8'd5, 1'b0, 1'b1, 1'b1, ac);
        expect_result("clean_after", 8'd17, 1'b0, rc);
        check("err_sticky", err, 1);
        pulse_clr();
        check("err_cleared2", err, 0);

        send(8'd127, 8'h9C, 8'd0, 1'b0, 1'b1, 1'b1, ac);
        expect_result("neg_ovf", exp_neg, 1'b1, rc);

        // 32 x (-128*-128) reaches 2^19 and wraps the 20-bit accumulator.
        for (int i = 0; i < 32; i++)
            send(8'h80, 8'h80, 8'd0, 1'b0, i == 0, i == 31, ac);
        expect_result("acc_wrap", exp_wrap, 1'b1, rc);

        // Non-first beat after a completed packet: base 0, c ignored.
        send(8'd2, 8'd2, 8'd99, 1'b0, 1'b0, 1'b1, ac);
        expect_result("orphan", 8'd4, 1'b0, rc);

        // Backpressure.
        @(negedge CLK);
        out_ready = 1'b0;
        send(8'd2, 8'd3, 8'd1, 1'b0, 1'b1, 1'b1, ac);
        send(8'hFE, 8'd5, 8'd0, 1'b0, 1'b1, 1'b1, ac);
        repeat (4) @(negedge CLK);
        #1;
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_hold_data", out_data, 8'd7);
        @(negedge CLK);
        out_ready = 1'b1;
        expect_result("bp_first", 8'd7, 1'b0, rc);
        expect_result("bp_second", 8'hF6, 1'b0, rc);

        // Reset in the middle of a packet.
        check("pre_rst_err", err, 1);
        send(8'd1, 8'd1, 8'd0, 1'b0, 1'b1, 1'b0, ac);
        send(8'd1, 8'd1, 8'd0, 1'b0, 1'b0, 1'b0, ac);
        @(negedge CLK);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_ovf", out_ovf, 0);
        check("mid_rst_err", err, 0);
        @(negedge CLK);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        send(8'd2, 8'd3, 8'd1, 1'b0, 1'b1, 1'b1, ac);
        expect_result("post_rst", 8'd7, 1'b0, rc);
        repeat (5) @(negedge CLK);
        check("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
